fir_mac_sched: RTL and testbench
================================

# fir_mac_sched

Sequencing controller for a time-multiplexed 16-tap FIR filter built around a single multiply-accumulate unit. It owns the sample delay line and the programmable coefficient bank. It accepts one input sample per valid/ready handshake, steps the MAC through all taps (one tap per cycle), and presents the accumulated result on a valid/ready output. It sits between the sample source and the downstream consumer of the FIR output. It replaces the fully parallel 16-multiplier datapath where area matters more than throughput.

## Interface
- `TAPS`, 16, number of taps (power of two, at least 2)
- `DW`, 16, sample width, signed two's complement
- `CW`, 16, coefficient width, signed two's complement
- `AW`, 34, accumulator and output width
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: synchronous, active-high.
- `coef_we` in 1: coefficient write strobe.
- `coef_addr` in log2(TAPS): coefficient index.
- `coef_data` in CW: coefficient value.
- `in_valid` in 1, `in_ready` out 1, `in_data` in DW: sample input handshake.
- `out_valid` out 1, `out_ready` in 1, `out_data` out AW: result output handshake.
- `busy` out 1: high whenever state is not IDLE.
- `coef_drop` out 1: sticky flag; a coefficient write arrived while not in IDLE.

## Operation
- Storage:
  - delay line `d[0..TAPS-1]`, DW bits each.
  - coefficient bank `c[0..TAPS-1]`, CW bits each.
  - accumulator `acc`, AW bits.
  - tap counter `idx`, log2(TAPS) bits.
- Reset clears `d`, `c`, `acc`, `idx`, and `coef_drop`, and forces state IDLE.
- Reset values of outputs:
  - `in_ready`=1
  - `out_valid`=0
  - `out_data`=0
  - `busy`=0
  - `coef_drop`=0
- FSM states:
  - IDLE:
    - `in_ready`=1.
    - On `in_valid`: shift the delay line (`d[0]`←`in_data`, `d[k]`←`d[k-1]`), clear `acc`, set `idx`=0, go to MAC.
  - MAC:
    - `in_ready`=0.
    - Each cycle: `acc` ← `acc` + sext(`d[idx]`×`c[idx]`), then `idx`++.
    - When `idx`=TAPS-1 is processed, go to OUT.
  - OUT:
    - `out_valid`=1 and `out_data`=`acc`, both held stable until `out_ready`.
    - On `out_valid`&&`out_ready`, go to IDLE.
- Arithmetic:
  - Signed DW×CW product, sign-extended to AW.
  - Accumulation wraps modulo 2^AW; there is no saturation.
  - Full precision requires AW ≥ DW+CW+log2(TAPS). The default AW is the system output width; the coefficient set must keep |Σ| below 2^33.
- Coefficient writes:
  - In IDLE, `coef_we` writes `c[coef_addr]` on that edge.
  - Outside IDLE the write is discarded and `coef_drop` is set (sticky until reset).
  - A write coinciding with a sample accept in IDLE takes effect before the MAC pass, so that sample uses the new coefficient.
- `out_data` holds its last value after the transfer and updates only on entry to OUT.

## Timing
- Accept edge E0: `in_valid`&&`in_ready` in IDLE.
- MAC occupies edges E1..E16.
- `out_valid` rises in the cycle after E16, i.e. 16 cycles after acceptance.
- Minimum sample period is 18 cycles: 1 IDLE + 16 MAC + 1 OUT with `out_ready` already high.
- `in_ready` is a registered function of state only; it is never combinationally dependent on `out_ready`.
- Backpressure:
  - With `out_ready` low, the block stays in OUT indefinitely.
  - `in_ready` stays 0 and no sample is lost on the source side.
- Reset asserted in MAC or OUT:
  - Next cycle: IDLE, `out_valid`=0, delay line and coefficients cleared.
  - The partial result is discarded and never presented.
- `in_valid` during MAC/OUT is ignored; the source holds the sample until `in_ready`.

## Test plan
- **Impulse response:** after reset, write `c[k]`=k+1, then feed 1 followed by 19 zeros.
  - Outputs are 1,2,…,16, then 0,0,0,0.
  - Each `out_valid` rises exactly 16 cycles after its accept edge.
- **Step:** write all `c[k]`=1, then feed `in_data`=5 for 20 samples.
  - Outputs are 5,10,…,80, then remain 80.
- **Backpressure:** hold `out_ready`=0 for 10 cycles while in OUT.
  - `out_valid`=1 and `out_data` stay constant.
  - `in_ready`=0 throughout.
  - Release transfers exactly once.
- **Signed extremes:** write `c[0]`=0xFFFF (−1), all others 0, then feed −32768.
  - `out_data`=32768.
  - Then feed 32767: `out_data`=(−32767 mod 2^34).
- **Write while busy:** pulse `coef_we` (addr 0, data 7) during MAC.
  - The write is dropped and `coef_drop`=1.
  - The current and next outputs use the old `c[0]`.
- **Mid-MAC reset:** assert `reset` for one cycle at MAC cycle 8.
  - `out_valid` never rises for that sample.
  - Outputs return to reset values.
  - A following impulse test (coefficients rewritten) reproduces 1..16.

Source files
------------

// File: rtl/fir_mac_sched.sv
// rtl/fir_mac_sched.sv - sequencer for a 16-tap FIR filter built around one multiply-accumulate unit
// Owns the delay line and coefficient bank, and runs one tap per cycle between sample accept and result.
module fir_mac_sched #(
  parameter int TAPS = 16,
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int AW   = 34
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [CW-1:0]            coef_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AW-1:0]            out_data,
  output logic                     busy,
  output logic                     coef_drop
);

  localparam int IW = $clog2(TAPS);
  localparam int PW = DW + CW;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t        state, state_next;
  logic [DW-1:0] d [TAPS];
  logic [CW-1:0] c [TAPS];
  logic [AW-1:0] acc;
  logic [IW-1:0] idx;
  logic [PW-1:0] prod;
  logic [AW-1:0] acc_next;
  logic          last_tap;

  // Both operands are widened to the full product width, so truncating the product loses nothing.
  always_comb begin
    prod     = $signed({{CW{d[idx][DW-1]}}, d[idx]}) * $signed({{DW{c[idx][CW-1]}}, c[idx]});
    acc_next = acc + {{(AW-PW){prod[PW-1]}}, prod};
    last_tap = (idx == IW'(TAPS-1));
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = MAC;
      end
      MAC: begin
        if (last_tap) state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        d[k] <= '0;
        c[k] <= '0;
      end
      acc       <= '0;
      idx       <= '0;
      out_data  <= '0;
      coef_drop <= 1'b0;
    end else begin
      // Coefficients may only change between passes; late writes are flagged, not applied.
      if (coef_we) begin
        if (state == IDLE) c[coef_addr] <= coef_data;
        else               coef_drop    <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int k = TAPS-1; k > 0; k--) d[k] <= d[k-1];
            d[0] <= in_data;
            acc  <= '0;
            idx  <= '0;
          end
        end
        MAC: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
          if (last_tap) out_data <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// tb/tb_fir_mac_sched.sv - scoreboard bench for fir_mac_sched
module tb_fir_mac_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [15:0] coef_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] out_data;
  logic        busy;
  logic        coef_drop;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  logic [33:0] exp_q[$];
  int          acc_q[$];
  logic        prev_ov     = 1'b0;

  fir_mac_sched dut (
    .clk       (clk),
    .reset     (reset),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .coef_drop (coef_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output side of the scoreboard: every transfer pops one expectation, every rise is 16 cycles after its accept.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) check("unexpected_rise", out_valid, 1'b0);
        else                   check("latency", 64'(cyc - acc_q.pop_front()), 64'd16);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", out_valid, 1'b0);
        else                   check("out_data", out_data, exp_q.pop_front());
      end
    end
    prev_ov = reset ? 1'b0 : out_valid;
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [15:0] x, input logic [33:0] e, input bit push);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_wait", in_ready, 1'b1);
      return;
    end
    in_valid = 1'b1;
    in_data  = x;
    if (push) begin
      exp_q.push_back(e);
      acc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wcoef(input logic [3:0] a, input logic [15:0] v);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = v;
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready,  1'b1);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_data"},  out_data,  34'd0);
    check({tag, "_busy"},      busy,      1'b0);
    check({tag, "_coef_drop"}, coef_drop, 1'b0);
  endtask

  task automatic impulse_test();
    for (int k = 0; k < 16; k++) wcoef(4'(k), 16'(k + 1));
    for (int i = 0; i < 20; i++) send((i == 0) ? 16'd1 : 16'd0, (i < 16) ? 34'(i + 1) : 34'd0, 1'b1);
    drain();
  endtask

  initial begin
    int n;
    int seen;
    reset     = 1'b1;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("reset");

    impulse_test();

    for (int k = 0; k < 16; k++) wcoef(4'(k), 16'd1);
    for (int i = 0; i < 20; i++) send(16'd5, 34'((i < 16 ? i + 1 : 16) * 5), 1'b1);
    drain();

    // Backpressure: the result must sit untouched in OUT with the input side closed.
    out_ready = 1'b0;
    send(16'd5, 34'd80, 1'b1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_rise", out_valid, 1'b1);
    repeat (10) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1'b1);
      check("bp_data", out_data, 34'd80);
      check("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_once_valid", out_valid, 1'b0);
    check("bp_once_queue", 64'(exp_q.size()), 64'd0);
    check("bp_hold_data", out_data, 34'd80);

    wcoef(4'd0, 16'hFFFF);
    for (int k = 1; k < 16; k++) wcoef(4'(k), 16'd0);
    send(16'h8000, 34'd32768, 1'b1);
    send(16'h7FFF, 34'(-32767), 1'b1);
    drain();

    // Write while busy: dropped, flagged, and the old c[0] stays in force.
    send(16'd100, 34'(-100), 1'b1);
    repeat (3) @(negedge clk);
    check("busy_in_mac", busy, 1'b1);
    wcoef(4'd0, 16'd7);
    check("coef_drop", coef_drop, 1'b1);
    drain();
    send(16'd3, 34'(-3), 1'b1);
    drain();
    check("coef_drop_sticky", coef_drop, 1'b1);

    // Mid-MAC reset: the in-flight sample must never be presented.
    send(16'd1, 34'd0, 1'b0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("midreset");
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midreset_no_out", 64'(seen), 64'd0);
    impulse_test();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
